// File: rtl/seg_scan_mux_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
package seg_disp_pkg;

    localparam int unsigned DIGIT_W    = 5;
    localparam logic [DIGIT_W-1:0] BLANK_CODE = 5'd31;
    localparam int unsigned MAX_DIGITS = 16;

    typedef enum logic [1:0] {
        IDLE,
        GUARD,
        ON
    } scan_state_e;

    function automatic logic [DIGIT_W-1:0] digit_slice(
        input logic [MAX_DIGITS*DIGIT_W-1:0] vec,
        input int unsigned                   idx
    );
        return DIGIT_W'(vec >> (idx * DIGIT_W));
    endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Digit load / display drive bundle between a host and seg_scan_mux.
interface seg_scan_mux_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    import seg_disp_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    logic                          enable;
    logic                          load;
    logic [NUM_DIGITS*DIGIT_W-1:0] digits_in;
    logic [DIGIT_W-1:0]            digit_code;
    logic [NUM_DIGITS-1:0]         anode_n;
    logic [IDX_W-1:0]              digit_idx;
    logic                          frame_done;

    modport master (
        output enable, load, digits_in,
        input  digit_code, anode_n, digit_idx, frame_done
    );

    modport slave (
        input  enable, load, digits_in,
        output digit_code, anode_n, digit_idx, frame_done
    );

endinterface

// File: rtl/seg_scan_prescaler.sv
// Per-slot cycle counter: wraps at REFRESH_DIV-1, flags guard end and slot end.
module seg_scan_prescaler #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tc,
    output logic guard_done
);
    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || tc) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CNT_W'(REFRESH_DIV - 1));

    generate
        if (GUARD_CYCLES == 0) begin : g_no_guard
            assign guard_done = 1'b0;
        end else begin : g_guard
            assign guard_done = (cnt_q == CNT_W'(GUARD_CYCLES - 1));
        end
    endgenerate

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed common-anode 7-segment scan controller with frame-aligned digit updates.
// Optional macro LEADING_ZERO_BLANK_EN blanks zero digits above the most significant non-zero digit.
module seg_scan_mux #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    seg_scan_mux_if.slave   bus
);
    import seg_disp_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned VEC_W = NUM_DIGITS * DIGIT_W;

    scan_state_e           state_q, state_d;
    logic [VEC_W-1:0]      pending_q, pending_d;
    logic [VEC_W-1:0]      active_q, active_d;
    logic [VEC_W-1:0]      fresh;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DIGIT_W-1:0]    code_q, code_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic                  fd_q, fd_d;
    logic                  clr, tc, guard_done, last_slot;

    function automatic logic [DIGIT_W-1:0] eff_code(
        input logic [VEC_W-1:0] act,
        input logic [IDX_W-1:0] idx
    );
        logic [MAX_DIGITS*DIGIT_W-1:0] wide;
        logic [DIGIT_W-1:0]            code;
`ifdef LEADING_ZERO_BLANK_EN
        logic                          upper_zero;
`endif
        wide             = '0;
        wide[VEC_W-1:0]  = act;
        code             = digit_slice(wide, 32'(idx));
`ifdef LEADING_ZERO_BLANK_EN
        upper_zero = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (i >= 32'(idx) && digit_slice(wide, i) != '0) begin
                upper_zero = 1'b0;
            end
        end
        if (idx != '0 && upper_zero) begin
            code = BLANK_CODE;
        end
`endif
        return code;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [IDX_W-1:0] idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

    seg_scan_prescaler #(
        .REFRESH_DIV  (REFRESH_DIV),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .tc         (tc),
        .guard_done (guard_done)
    );

    // A load on the same edge as a frame update must win over the stale pending copy.
    assign fresh     = bus.load ? bus.digits_in : pending_q;
    assign last_slot = (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign clr       = (state_q == IDLE) || !bus.enable;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        code_d    = code_q;
        anode_d   = anode_q;
        fd_d      = 1'b0;
        pending_d = fresh;
        active_d  = active_q;

        case (state_q)
            IDLE: begin
                active_d = fresh;
                idx_d    = '0;
                code_d   = BLANK_CODE;
                anode_d  = '1;
                if (bus.enable) begin
                    code_d = eff_code(active_d, '0);
                    if (GUARD_CYCLES == 0) begin
                        state_d = ON;
                        anode_d = anode_for('0);
                    end else begin
                        state_d = GUARD;
                    end
                end
            end
            GUARD: begin
                if (guard_done) begin
                    state_d = ON;
                    anode_d = anode_for(idx_q);
                end
            end
            ON: begin
                if (tc) begin
                    idx_d = last_slot ? '0 : idx_q + IDX_W'(1);
                    if (last_slot) begin
                        fd_d     = 1'b1;
                        active_d = fresh;
                    end
                    code_d = eff_code(active_d, idx_d);
                    if (GUARD_CYCLES == 0) begin
                        anode_d = anode_for(idx_d);
                    end else begin
                        state_d = GUARD;
                        anode_d = '1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!bus.enable) begin
            state_d = IDLE;
            idx_d   = '0;
            code_d  = BLANK_CODE;
            anode_d = '1;
            fd_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            active_q  <= '0;
            idx_q     <= '0;
            code_q    <= BLANK_CODE;
            anode_q   <= '1;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            idx_q     <= idx_d;
            code_q    <= code_d;
            anode_q   <= anode_d;
            fd_q      <= fd_d;
        end
    end

    assign bus.digit_code = code_q;
    assign bus.anode_n    = anode_q;
    assign bus.digit_idx  = idx_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux with NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2.
module tb_seg_scan_mux;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic [4:0] exp_q[$];

    seg_scan_mux_if #(.NUM_DIGITS(4)) bus ();

    seg_scan_mux #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (8),
        .GUARD_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] exp_code(input logic [19:0] d, input int s);
        logic [19:0] sh;
        logic [4:0]  v;
        sh = d >> (s * 5);
        v  = sh[4:0];
`ifdef LEADING_ZERO_BLANK_EN
        if (s > 0 && sh == 20'd0) v = 5'd31;
`endif
        return v;
    endfunction

    task automatic push_frame(input logic [19:0] d);
        for (int s = 0; s < 4; s++) exp_q.push_back(exp_code(d, s));
    endtask

    // Checks one 8-cycle slot; optionally drives load at cycle load_at or drops enable at dis_at.
    task automatic check_slot(input int s, input bit fd_first, input int load_at,
                              input logic [19:0] load_val, input int dis_at);
        logic [4:0] ec;
        logic [3:0] ea;
        logic [1:0] ei;
        logic       ef;
        ei = 2'(s);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty slot %0d: got empty queue, want entry", s);
            ec = 5'bx;
        end else begin
            ec = exp_q.pop_front();
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            ea = (c < 2) ? 4'hF : ~(4'b0001 << s);
            ef = (c == 0) && fd_first;
            checks++;
            if (bus.anode_n !== ea) begin
                errors++;
                $display("FAIL anode slot %0d cyc %0d: got %b want %b", s, c, bus.anode_n, ea);
            end
            checks++;
            if (bus.digit_code !== ec) begin
                errors++;
                $display("FAIL code slot %0d cyc %0d: got %0d want %0d", s, c, bus.digit_code, ec);
            end
            checks++;
            if (bus.digit_idx !== ei) begin
                errors++;
                $display("FAIL idx slot %0d cyc %0d: got %0d want %0d", s, c, bus.digit_idx, ei);
            end
            checks++;
            if (bus.frame_done !== ef) begin
                errors++;
                $display("FAIL frame_done slot %0d cyc %0d: got %b want %b", s, c, bus.frame_done, ef);
            end
            if (c == load_at) begin
                bus.load      = 1'b1;
                bus.digits_in = load_val;
            end else begin
                bus.load = 1'b0;
            end
            if (c == dis_at) begin
                bus.enable = 1'b0;
                return;
            end
        end
    endtask

    task automatic check_dark(input string name, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            checks++;
            if (bus.anode_n !== 4'hF || bus.digit_code !== 5'd31 ||
                bus.digit_idx !== 2'd0 || bus.frame_done !== 1'b0) begin
                errors++;
                $display("FAIL %s cyc %0d: got anode=%b code=%0d idx=%0d fd=%b want anode=1111 code=31 idx=0 fd=0",
                         name, c, bus.anode_n, bus.digit_code, bus.digit_idx, bus.frame_done);
            end
        end
    endtask

    task automatic start_scan(input logic [19:0] d);
        @(negedge clk);
        bus.load      = 1'b1;
        bus.digits_in = d;
        @(negedge clk);
        bus.load   = 1'b0;
        bus.enable = 1'b1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.enable    = 1'b0;
        bus.load      = 1'b0;
        bus.digits_in = '0;
        check_dark("reset_hold", 3);
        rst_n = 1'b1;
        check_dark("post_reset_idle", 4);
    endtask

    task automatic test_scan();
        start_scan({5'd1, 5'd2, 5'd3, 5'd4});
        push_frame({5'd1, 5'd2, 5'd3, 5'd4});
        push_frame({5'd1, 5'd2, 5'd3, 5'd4});
        for (int f = 0; f < 2; f++)
            for (int s = 0; s < 4; s++)
                check_slot(s, (s == 0) && (f == 1), -1, '0, -1);
    endtask

    task automatic test_midframe_load();
        push_frame({5'd1, 5'd2, 5'd3, 5'd4});
        for (int s = 0; s < 4; s++)
            check_slot(s, s == 0, (s == 1) ? 3 : -1, {5'd9, 5'd9, 5'd9, 5'd9}, -1);
    endtask

    task automatic test_boundary_load();
        push_frame({5'd9, 5'd9, 5'd9, 5'd9});
        for (int s = 0; s < 4; s++)
            check_slot(s, s == 0, (s == 3) ? 7 : -1, {5'd12, 5'd0, 5'd6, 5'd8}, -1);
    endtask

    task automatic test_disable();
        for (int s = 0; s < 3; s++) exp_q.push_back(exp_code({5'd12, 5'd0, 5'd6, 5'd8}, s));
        check_slot(0, 1'b1, -1, '0, -1);
        check_slot(1, 1'b0, -1, '0, -1);
        check_slot(2, 1'b0, -1, '0, 4);
        check_dark("disabled", 40);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.enable = 1'b1;
        repeat (13) @(negedge clk);
        rst_n = 1'b0;
        check_dark("mid_reset", 1);
        rst_n = 1'b1;
        push_frame(20'd0);
        for (int s = 0; s < 4; s++) check_slot(s, 1'b0, -1, '0, -1);
        bus.enable = 1'b0;
    endtask

    task automatic test_lzb();
        check_dark("lzb_idle", 2);
        start_scan({5'd0, 5'd0, 5'd7, 5'd0});
        push_frame({5'd0, 5'd0, 5'd7, 5'd0});
        for (int s = 0; s < 4; s++) check_slot(s, 1'b0, -1, '0, -1);
        bus.enable = 1'b0;
        start_scan(20'd0);
        push_frame(20'd0);
        for (int s = 0; s < 4; s++) check_slot(s, 1'b0, -1, '0, -1);
        bus.enable = 1'b0;
        check_dark("lzb_off", 3);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_scan();
        test_midframe_load();
        test_boundary_load();
        test_disable();
        test_reset_mid();
        test_lzb();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
